mole_scheduler: RTL and testbench
=================================

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 The block SHALL have the parameter SHOW_TICKS, default 20, meaning the number of I_tick strobes a mole stays up (legal range 1..255).
REQ-002 The block SHALL have the parameter GAP_MIN, default 4, meaning the minimum number of I_tick strobes between moles (legal range 1..239).
REQ-003 The block SHALL have the parameter ROUNDS, default 10, meaning the number of moles per game (legal range 1..255).
REQ-004 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-005 I_clk  input  1  system clock.
REQ-006 I_rst  input  1  asynchronous active-high reset.
REQ-007 I_start  input  1  one-cycle pulse that starts a game.
REQ-008 I_stop  input  1  one-cycle pulse that aborts a game.
REQ-009 I_tick  input  1  one-cycle timebase strobe (e.g. 1 ms).
REQ-010 I_rand  input  16  free-running pseudo-random word from the LFSR.
REQ-011 I_key  input  8  one-cycle press pulses, one bit per hole.
REQ-012 O_mole  output  8  one-hot mole position, all zeros when no mole is up.
REQ-013 O_hit  output  1  one-cycle pulse on a hit.
REQ-014 O_miss  output  1  one-cycle pulse on a timeout.
REQ-015 O_score  output  8  hit count.
REQ-016 O_round  output  8  count of moles shown so far.
REQ-017 O_busy  output  1  high while in the GAP or SHOW state.
REQ-018 O_done  output  1  high while in the DONE state.

Function
REQ-019 The block SHALL implement the states IDLE, GAP, SHOW and DONE, and all outputs SHALL be registered.
REQ-020 In IDLE or DONE, I_start SHALL clear O_score and O_round, load the gap target, and enter GAP on the next cycle.
REQ-021 I_start SHALL be ignored in GAP and SHOW.
REQ-022 On GAP entry, the gap target SHALL be GAP_MIN + I_rand[11:8] (range GAP_MIN..GAP_MIN+15), sampled in the entry cycle.
REQ-023 In GAP, a tick counter SHALL increment on each I_tick, and the I_tick that makes the count equal the target SHALL cause SHOW entry on the next clock.
REQ-024 On SHOW entry, the candidate position SHALL be p = I_rand[2:0] sampled on the transition cycle, and if p equals the previous position, p+1 mod 8 SHALL be used instead (no repeats).
REQ-025 O_mole SHALL be set one-hot to the chosen position in the same cycle the state becomes SHOW, and O_round SHALL increment in that cycle.
REQ-026 In SHOW, if (I_key & O_mole) != 0, the block SHALL deassert O_mole, pulse O_hit, increment O_score (saturating at 255), and clear it in the next cycle.
REQ-027 In SHOW, the SHOW_TICKS-th I_tick without a hit SHALL deassert O_mole and pulse O_miss in the next cycle.
REQ-028 In SHOW, keys that do not match O_mole SHALL be ignored.
REQ-029 If a hit and the final I_tick occur in the same cycle, the hit SHALL win: O_hit pulses, O_miss does not, and the score increments.
REQ-030 After a hit or miss, if O_round == ROUNDS the block SHALL go to DONE, otherwise it SHALL go to GAP with a newly sampled gap target.
REQ-031 In DONE, O_done SHALL be high, O_mole SHALL be 0, and O_score and O_round SHALL be held.
REQ-032 I_stop in any state SHALL go to IDLE next cycle, clear O_mole, produce no O_hit or O_miss, and hold O_score and O_round.
REQ-033 If I_stop and I_start occur in the same cycle, I_stop SHALL win.
REQ-034 I_tick and I_key SHALL have no effect in IDLE or DONE.
REQ-035 The previous-position register SHALL be initialised to 7 by reset and by I_start.

Reset
REQ-036 While I_rst is high, the block SHALL be in IDLE with O_mole=0, O_hit=0, O_miss=0, O_score=0, O_round=0, O_busy=0, O_done=0 and all tick counters at 0.
REQ-037 Reset asserted mid-game SHALL abort immediately, with no pulse emitted.

Verification
REQ-038 Scenario: I_rand=16'h0305 held, start, ticks every 10 clocks -> GAP lasts 7 ticks, then O_mole=8'h20 and O_round=1.
REQ-039 Scenario: with a mole at hole 5, I_key=8'h20 before the timeout -> next cycle O_hit=1 for 1 cycle, O_score=1, O_mole=0.
REQ-040 Scenario: with a mole up, no key for 20 ticks -> O_miss pulses once and O_score is unchanged; I_key=8'h01 while O_mole=8'h20 -> no hit.
REQ-041 Scenario: I_rand[2:0]=5 on two consecutive rounds -> the second O_mole=8'h40.
REQ-042 Scenario: ROUNDS=2, hit both -> O_done=1, O_score=2, O_round=2; then start -> counters cleared, O_busy=1.
REQ-043 Scenario: the correct key and the 20th tick in the same cycle -> O_hit only; I_stop mid-SHOW -> IDLE with O_mole=0 and the score held; I_rst mid-GAP -> all outputs 0.

Source files
------------

// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: random gap, random hole with no immediate repeat,
// hit/miss detection and score/round bookkeeping. All outputs come straight from flops.
module mole_scheduler #(
    parameter int SHOW_TICKS = 20,
    parameter int GAP_MIN    = 4,
    parameter int ROUNDS     = 10
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_start,
    input  logic        I_stop,
    input  logic        I_tick,
    input  logic [15:0] I_rand,
    input  logic [7:0]  I_key,
    output logic [7:0]  O_mole,
    output logic        O_hit,
    output logic        O_miss,
    output logic [7:0]  O_score,
    output logic [7:0]  O_round,
    output logic        O_busy,
    output logic        O_done
);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_SHOW, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] gap_tgt_q, gap_tgt_d;
    logic [7:0] show_cnt_q, show_cnt_d;
    logic [2:0] prev_q, prev_d;
    logic [7:0] mole_q, mole_d;
    logic       hit_q, hit_d;
    logic       miss_q, miss_d;
    logic [7:0] score_q, score_d;
    logic [7:0] round_q, round_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [7:0] gap_tgt_new;
    logic [2:0] cand, pos;
    logic       key_hit, last_tick;

    always_comb begin
        gap_tgt_new = 8'(GAP_MIN) + {4'd0, I_rand[11:8]};
        cand        = I_rand[2:0];
        pos         = (cand == prev_q) ? cand + 3'd1 : cand;
        key_hit     = |(I_key & mole_q);
        last_tick   = I_tick && ((show_cnt_q + 8'd1) == 8'(SHOW_TICKS));

        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        gap_tgt_d  = gap_tgt_q;
        show_cnt_d = show_cnt_q;
        prev_d     = prev_q;
        mole_d     = mole_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        score_d    = score_q;
        round_d    = round_q;

        if (I_stop) begin
            // Abort silently: the score and round are kept for display.
            state_d    = S_IDLE;
            mole_d     = 8'd0;
            gap_cnt_d  = 8'd0;
            show_cnt_d = 8'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (I_start) begin
                        state_d   = S_GAP;
                        score_d   = 8'd0;
                        round_d   = 8'd0;
                        gap_tgt_d = gap_tgt_new;
                        gap_cnt_d = 8'd0;
                        prev_d    = 3'd7;
                    end
                end
                S_GAP: begin
                    if (I_tick) begin
                        if ((gap_cnt_q + 8'd1) == gap_tgt_q) begin
                            state_d    = S_SHOW;
                            mole_d     = 8'd1 << pos;
                            prev_d     = pos;
                            round_d    = round_q + 8'd1;
                            gap_cnt_d  = 8'd0;
                            show_cnt_d = 8'd0;
                        end else begin
                            gap_cnt_d = gap_cnt_q + 8'd1;
                        end
                    end
                end
                S_SHOW: begin
                    // A hit on the final tick still counts as a hit.
                    if (key_hit || last_tick) begin
                        mole_d     = 8'd0;
                        hit_d      = key_hit;
                        miss_d     = !key_hit;
                        show_cnt_d = 8'd0;
                        if (key_hit && score_q != 8'hFF)
                            score_d = score_q + 8'd1;
                        if (round_q == 8'(ROUNDS)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d   = S_GAP;
                            gap_tgt_d = gap_tgt_new;
                            gap_cnt_d = 8'd0;
                        end
                    end else if (I_tick) begin
                        show_cnt_d = show_cnt_q + 8'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_GAP) || (state_d == S_SHOW);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= S_IDLE;
            gap_cnt_q  <= 8'd0;
            gap_tgt_q  <= 8'd0;
            show_cnt_q <= 8'd0;
            prev_q     <= 3'd7;
            mole_q     <= 8'd0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            score_q    <= 8'd0;
            round_q    <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            gap_tgt_q  <= gap_tgt_d;
            show_cnt_q <= show_cnt_d;
            prev_q     <= prev_d;
            mole_q     <= mole_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            score_q    <= score_d;
            round_q    <= round_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign O_mole  = mole_q;
    assign O_hit   = hit_q;
    assign O_miss  = miss_q;
    assign O_score = score_q;
    assign O_round = round_q;
    assign O_busy  = busy_q;
    assign O_done  = done_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler (ROUNDS=2): gap timing, no-repeat hole choice,
// hit/miss/tie, DONE, stop/start priority and asynchronous reset.
module tb_mole_scheduler;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic        I_start = 1'b0;
    logic        I_stop = 1'b0;
    logic        I_tick = 1'b0;
    logic [15:0] I_rand = 16'h0000;
    logic [7:0]  I_key = 8'h00;
    logic [7:0]  O_mole;
    logic        O_hit;
    logic        O_miss;
    logic [7:0]  O_score;
    logic [7:0]  O_round;
    logic        O_busy;
    logic        O_done;

    int n_chk = 0;
    int n_err = 0;

    mole_scheduler #(.SHOW_TICKS(20), .GAP_MIN(4), .ROUNDS(2)) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_start(I_start), .I_stop(I_stop),
        .I_tick(I_tick), .I_rand(I_rand), .I_key(I_key),
        .O_mole(O_mole), .O_hit(O_hit), .O_miss(O_miss), .O_score(O_score),
        .O_round(O_round), .O_busy(O_busy), .O_done(O_done)
    );

    always #5 I_clk = ~I_clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge I_clk);
    endtask

    // One tick strobe followed by two quiet cycles.
    task automatic tick();
        I_tick = 1'b1;
        cyc();
        I_tick = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mole"},  {8'd0, O_mole}, 16'h0);
        chk({tag, "_hit"},   {15'd0, O_hit}, 16'h0);
        chk({tag, "_miss"},  {15'd0, O_miss}, 16'h0);
        chk({tag, "_score"}, {8'd0, O_score}, 16'h0);
        chk({tag, "_round"}, {8'd0, O_round}, 16'h0);
        chk({tag, "_busy"},  {15'd0, O_busy}, 16'h0);
        chk({tag, "_done"},  {15'd0, O_done}, 16'h0);
    endtask

    initial begin
        cyc();
        cyc();
        chk_all_zero("reset");
        I_rst = 1'b0;
        cyc();

        // Game 1: target 4+3=7 ticks, hole 5.
        I_rand = 16'h0305;
        I_start = 1'b1;
        cyc();
        I_start = 1'b0;
        chk("start_busy", {15'd0, O_busy}, 16'h1);
        chk("start_round", {8'd0, O_round}, 16'h0);
        for (int i = 0; i < 6; i++) tick();
        chk("gap6_mole", {8'd0, O_mole}, 16'h0);
        tick();
        chk("gap7_mole", {8'd0, O_mole}, 16'h20);
        chk("gap7_round", {8'd0, O_round}, 16'h1);

        I_key = 8'h01;
        cyc();
        I_key = 8'h00;
        chk("wrongkey_hit", {15'd0, O_hit}, 16'h0);
        chk("wrongkey_mole", {8'd0, O_mole}, 16'h20);

        I_key = 8'h20;
        cyc();
        I_key = 8'h00;
        chk("hit1_hit", {15'd0, O_hit}, 16'h1);
        chk("hit1_score", {8'd0, O_score}, 16'h1);
        chk("hit1_mole", {8'd0, O_mole}, 16'h0);
        cyc();
        chk("hit1_pulse_end", {15'd0, O_hit}, 16'h0);
        chk("hit1_busy", {15'd0, O_busy}, 16'h1);

        // Round 2: same random hole 5 must advance to 6.
        for (int i = 0; i < 7; i++) tick();
        chk("norepeat_mole", {8'd0, O_mole}, 16'h40);
        chk("round2", {8'd0, O_round}, 16'h2);
        for (int i = 0; i < 19; i++) tick();
        chk("tie_pre_mole", {8'd0, O_mole}, 16'h40);
        I_tick = 1'b1;
        I_key = 8'h40;
        cyc();
        I_tick = 1'b0;
        I_key = 8'h00;
        chk("tie_hit", {15'd0, O_hit}, 16'h1);
        chk("tie_miss", {15'd0, O_miss}, 16'h0);
        chk("done_flag", {15'd0, O_done}, 16'h1);
        chk("done_busy", {15'd0, O_busy}, 16'h0);
        chk("done_score", {8'd0, O_score}, 16'h2);
        chk("done_round", {8'd0, O_round}, 16'h2);

        // DONE ignores ticks and keys.
        I_key = 8'hFF;
        tick();
        I_key = 8'h00;
        chk("done_hold_mole", {8'd0, O_mole}, 16'h0);
        chk("done_hold_score", {8'd0, O_score}, 16'h2);
        chk("done_hold_flag", {15'd0, O_done}, 16'h1);

        // Game 2 from DONE: target 4, hole 5 again (previous reset to 7).
        I_rand = 16'h0005;
        I_start = 1'b1;
        cyc();
        I_start = 1'b0;
        chk("restart_score", {8'd0, O_score}, 16'h0);
        chk("restart_round", {8'd0, O_round}, 16'h0);
        chk("restart_busy", {15'd0, O_busy}, 16'h1);
        chk("restart_done", {15'd0, O_done}, 16'h0);
        for (int i = 0; i < 4; i++) tick();
        chk("g2_mole", {8'd0, O_mole}, 16'h20);

        for (int i = 0; i < 19; i++) tick();
        chk("miss_pre", {8'd0, O_mole}, 16'h20);
        I_tick = 1'b1;
        cyc();
        I_tick = 1'b0;
        chk("miss_pulse", {15'd0, O_miss}, 16'h1);
        chk("miss_hit", {15'd0, O_hit}, 16'h0);
        chk("miss_mole", {8'd0, O_mole}, 16'h0);
        chk("miss_score", {8'd0, O_score}, 16'h0);
        cyc();
        chk("miss_pulse_end", {15'd0, O_miss}, 16'h0);

        for (int i = 0; i < 4; i++) tick();
        chk("g2r2_mole", {8'd0, O_mole}, 16'h40);
        // Stop beats start and key in the same cycle.
        I_stop = 1'b1;
        I_start = 1'b1;
        I_key = 8'h40;
        cyc();
        I_stop = 1'b0;
        I_start = 1'b0;
        I_key = 8'h00;
        chk("stop_mole", {8'd0, O_mole}, 16'h0);
        chk("stop_hit", {15'd0, O_hit}, 16'h0);
        chk("stop_busy", {15'd0, O_busy}, 16'h0);
        chk("stop_done", {15'd0, O_done}, 16'h0);
        chk("stop_round", {8'd0, O_round}, 16'h2);
        I_key = 8'h40;
        tick();
        I_key = 8'h00;
        chk("idle_ignore_mole", {8'd0, O_mole}, 16'h0);
        chk("idle_ignore_busy", {15'd0, O_busy}, 16'h0);

        // Reset asserted mid-GAP clears everything immediately.
        I_rand = 16'h0A03;
        I_start = 1'b1;
        cyc();
        I_start = 1'b0;
        chk("g3_busy", {15'd0, O_busy}, 16'h1);
        for (int i = 0; i < 3; i++) tick();
        I_rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        cyc();
        I_rst = 1'b0;
        cyc();
        chk_all_zero("postrst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
